spi_flash_responder: RTL and testbench
======================================

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 Parameter JEDEC_ID, 24'hEF4016, three ID bytes returned MSB-first for command 0x9F.
REQ-002 Parameter STATUS_VAL, 8'h00, byte returned for command 0x05.
REQ-003 Port clk  input  1  single system clock; all logic in this domain; clk SHALL be at least 16x the spi_sck frequency.
REQ-004 Port resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 spi_sck, spi_cs, spi_mosi  input  1 each  SPI mode 0 from the bootloader SPI master; spi_cs is active-low.
REQ-006 spi_miso  output  1  serial data to the master.
REQ-007 spi_miso_oe  output  1  high only while spi_cs is low and the block is in a data phase.
REQ-008 mem_req  output  1  byte read request; mem_addr  output  24  byte address.
REQ-009 mem_ack  input  1  one-cycle data-valid strobe; mem_rdata  input  8  read byte.
REQ-010 cmd_strobe  output  1  one-cycle pulse when a command byte completes; cmd  output  8  last command byte.
REQ-011 underrun  output  1  sticky flag: a data byte was needed before mem_ack arrived.

Function
REQ-012 spi_sck, spi_cs and spi_mosi SHALL each pass a 2-flop synchronizer; edges are detected on the synchronized signals.
REQ-013 On each rising sck edge with cs low, mosi is shifted in MSB-first; a 3-bit counter marks byte boundaries.
REQ-014 On each falling sck edge in a data phase, the shift-out register advances one bit; spi_miso always shows its MSB.
REQ-015 States: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE; cs falling edge moves IDLE->CMD and clears the bit counter.
REQ-016 CMD byte 0x9F SHALL go to DATA with the JEDEC_ID bytes, then 8'h00 for every further byte.
REQ-017 CMD byte 0x05 SHALL go to DATA and repeat STATUS_VAL for every byte.
REQ-018 CMD byte 0x03 SHALL go to ADDR, take 3 bytes MSB-first, then go to DATA.
REQ-019 Any other command byte SHALL go to IGNORE; spi_miso_oe stays 0 until cs rises.
REQ-020 mem_req SHALL rise on the cycle after the last address bit is captured, and again each time a prefetched byte is loaded into the shift-out register.
REQ-021 mem_req SHALL hold high until mem_ack, then drop for at least one cycle; mem_addr is stable while mem_req is high.
REQ-022 mem_addr SHALL increment by 1 per accepted byte and wrap from 24'hFFFFFF to 24'h000000.
REQ-023 If a byte boundary is reached in DATA before mem_ack, the block SHALL send 8'hFF for that byte, set underrun and keep the address sequence unchanged.
REQ-024 A cs rising edge in any state SHALL return the block to IDLE within 3 clk and drop spi_miso_oe.
REQ-025 A mem_req pending when cs rises SHALL stay high until mem_ack; the returned data is discarded.
REQ-026 underrun SHALL clear on the next cs falling edge.
REQ-027 cs deasserting mid-byte SHALL discard the partial byte without a cmd_strobe.

Reset
REQ-028 While resetn is low: state IDLE, spi_miso 0, spi_miso_oe 0, mem_req 0, mem_addr 0, cmd 0, cmd_strobe 0, underrun 0, synchronizers cleared to idle levels (cs=1, sck=0).
REQ-029 After resetn deasserts, a transaction already in progress (cs low) SHALL be ignored until cs goes high.

Configuration
REQ-030 Macro SPI_FLASH_RESP_FASTREAD_EN defined: command 0x0B goes ADDR (3 bytes) -> DUMMY (8 sck cycles, miso_oe 0) -> DATA; mem_req is issued at the end of ADDR.
REQ-031 Macro undefined: 0x0B SHALL be handled as an unsupported command (IGNORE).

Verification
REQ-032 Command 0x9F, 5 bytes clocked -> miso EF 40 16 00 00; cmd_strobe pulses once with cmd=9F.
REQ-033 Command 0x03, address 00 10 00, 4 bytes, mem_ack 2 clk after each mem_req -> mem_addr 001000..001003, data matches, underrun 0.
REQ-034 Command 0x03, address FF FF FF, 2 bytes -> mem_addr FFFFFF then 000000.
REQ-035 Command 0x03 with mem_ack withheld -> first data byte FF, underrun 1; next cs falling edge -> underrun 0.
REQ-036 cs raised after 4 address bits -> IDLE within 3 clk, spi_miso_oe 0, no mem_req; resetn pulsed mid-DATA -> every output at its reset value.
REQ-037 Command 0x0B, address 000020, 8 dummy clocks -> FASTREAD_EN defined: data from 000020; undefined: spi_miso_oe stays 0.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: JEDEC ID (0x9F), status (0x05) and read (0x03) served from a byte-wide memory port.
// Define SPI_FLASH_RESP_FASTREAD_EN to also accept fast read (0x0B) with 8 dummy clocks; 0x0B is ignored otherwise.
module spi_flash_responder #(
   parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
   parameter logic [7:0]  STATUS_VAL = 8'h00
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        spi_sck,
   input  logic        spi_cs,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   output logic        mem_req,
   output logic [23:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic        cmd_strobe,
   output logic [7:0]  cmd,
   output logic        underrun
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
   typedef enum logic [1:0] {SRC_ID, SRC_STATUS, SRC_MEM} src_t;

   // [0] first flop, [1] synchronized value, [2] previous synchronized value
   logic [2:0] sck_sync_q, cs_sync_q;
   logic [1:0] mosi_sync_q;
   logic [1:0] fill_q;
   logic       armed_q;

   state_t      state_q, state_d;
   src_t        src_q, src_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  sr_in_q, sr_in_d;
   logic [15:0] addr_sh_q, addr_sh_d;
   logic [1:0]  addr_cnt_q, addr_cnt_d;
   logic [1:0]  id_idx_q, id_idx_d;
   logic [7:0]  sr_out_q, sr_out_d;
   logic [7:0]  buf_q, buf_d;
   logic        buf_valid_q, buf_valid_d;
   logic        mem_req_q, mem_req_d;
   logic [23:0] mem_addr_q, mem_addr_d;
   logic [7:0]  cmd_q, cmd_d;
   logic        cmd_strobe_q, cmd_strobe_d;
   logic        underrun_q, underrun_d;

   logic       sck_rise, sck_fall, cs_rise, cs_fall;
   logic [7:0] byte_in;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sck_sync_q  <= 3'b000;
         cs_sync_q   <= 3'b111;
         mosi_sync_q <= 2'b00;
         fill_q      <= 2'b00;
         armed_q     <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[1:0], spi_sck};
         cs_sync_q   <= {cs_sync_q[1:0], spi_cs};
         mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
         fill_q      <= {fill_q[0], 1'b1};
         // A transaction already running at reset release is skipped until cs is seen high.
         armed_q     <= armed_q | (fill_q[1] & cs_sync_q[1]);
      end
   end

   assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
   assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
   assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2] & armed_q;
   assign byte_in  = {sr_in_q, mosi_sync_q[1]};

   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      bit_cnt_d    = bit_cnt_q;
      sr_in_d      = sr_in_q;
      addr_sh_d    = addr_sh_q;
      addr_cnt_d   = addr_cnt_q;
      id_idx_d     = id_idx_q;
      sr_out_d     = sr_out_q;
      buf_d        = buf_q;
      buf_valid_d  = buf_valid_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      cmd_d        = cmd_q;
      cmd_strobe_d = 1'b0;
      underrun_d   = underrun_q;

      // A late acknowledge still completes after cs rises; its data is dropped in IDLE.
      if (mem_req_q && mem_ack) begin
         mem_req_d  = 1'b0;
         mem_addr_d = mem_addr_q + 24'd1;
         if (state_q != IDLE) begin
            buf_d       = mem_rdata;
            buf_valid_d = 1'b1;
         end
      end

      if (cs_rise) begin
         state_d = IDLE;
      end else if (cs_fall) begin
         state_d     = CMD;
         bit_cnt_d   = 3'd0;
         addr_cnt_d  = 2'd0;
         underrun_d  = 1'b0;
         buf_valid_d = 1'b0;
         sr_out_d    = 8'h00;
      end else if (state_q != IDLE && !cs_sync_q[1]) begin
         if (sck_rise) begin
            sr_in_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               case (state_q)
                  CMD: begin
                     cmd_d        = byte_in;
                     cmd_strobe_d = 1'b1;
                     case (byte_in)
                        8'h9F: begin
                           state_d  = DATA;
                           src_d    = SRC_ID;
                           id_idx_d = 2'd0;
                        end
                        8'h05: begin
                           state_d = DATA;
                           src_d   = SRC_STATUS;
                        end
                        8'h03: state_d = ADDR;
`ifdef SPI_FLASH_RESP_FASTREAD_EN
                        8'h0B: state_d = ADDR;
`endif
                        default: state_d = IGNORE;
                     endcase
                  end
                  ADDR: begin
                     addr_sh_d  = {addr_sh_q[7:0], byte_in};
                     addr_cnt_d = addr_cnt_q + 2'd1;
                     if (addr_cnt_q == 2'd2) begin
                        mem_addr_d  = {addr_sh_q, byte_in};
                        mem_req_d   = 1'b1;
                        buf_valid_d = 1'b0;
                        src_d       = SRC_MEM;
                        state_d     = DATA;
`ifdef SPI_FLASH_RESP_FASTREAD_EN
                        if (cmd_q == 8'h0B) state_d = DUMMY;
`endif
                     end
                  end
                  DUMMY:   state_d = DATA;
                  default: ;
               endcase
            end
         end else if (sck_fall && state_q == DATA) begin
            // Falling edge at a byte boundary loads the next byte so its MSB is set up before the next rising edge.
            if (bit_cnt_q == 3'd0) begin
               case (src_q)
                  SRC_ID: begin
                     case (id_idx_q)
                        2'd0:    sr_out_d = JEDEC_ID[23:16];
                        2'd1:    sr_out_d = JEDEC_ID[15:8];
                        2'd2:    sr_out_d = JEDEC_ID[7:0];
                        default: sr_out_d = 8'h00;
                     endcase
                     if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
                  end
                  SRC_STATUS: sr_out_d = STATUS_VAL;
                  default: begin
                     if (buf_valid_q) begin
                        sr_out_d    = buf_q;
                        buf_valid_d = 1'b0;
                        mem_req_d   = 1'b1;
                     end else begin
                        sr_out_d   = 8'hFF;
                        underrun_d = 1'b1;
                     end
                  end
               endcase
            end else begin
               sr_out_d = {sr_out_q[6:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         src_q        <= SRC_ID;
         bit_cnt_q    <= 3'd0;
         sr_in_q      <= 7'd0;
         addr_sh_q    <= 16'd0;
         addr_cnt_q   <= 2'd0;
         id_idx_q     <= 2'd0;
         sr_out_q     <= 8'h00;
         buf_q        <= 8'h00;
         buf_valid_q  <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= 24'd0;
         cmd_q        <= 8'h00;
         cmd_strobe_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         bit_cnt_q    <= bit_cnt_d;
         sr_in_q      <= sr_in_d;
         addr_sh_q    <= addr_sh_d;
         addr_cnt_q   <= addr_cnt_d;
         id_idx_q     <= id_idx_d;
         sr_out_q     <= sr_out_d;
         buf_q        <= buf_d;
         buf_valid_q  <= buf_valid_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         cmd_q        <= cmd_d;
         cmd_strobe_q <= cmd_strobe_d;
         underrun_q   <= underrun_d;
      end
   end

   assign spi_miso    = sr_out_q[7];
   assign spi_miso_oe = (state_q == DATA) & ~cs_sync_q[1];
   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign cmd         = cmd_q;
   assign cmd_strobe  = cmd_strobe_q;
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: bit-banged SPI master, acking memory model and spec-level expected bytes.
// Build with SPI_FLASH_RESP_FASTREAD_EN defined to cover fast read; otherwise 0x0B must stay silent.
module tb_spi_flash_responder;

   localparam int          HALF  = 10;
   localparam logic [23:0] JEDEC = 24'hEF4016;
   localparam logic [7:0]  STAT  = 8'h00;

   logic        clk, resetn, spi_sck, spi_cs, spi_mosi;
   logic        spi_miso, spi_miso_oe, mem_req, mem_ack, cmd_strobe, underrun;
   logic [23:0] mem_addr;
   logic [7:0]  mem_rdata, cmd;

   int errors = 0;
   int checks = 0;

   logic        ack_en = 1'b1;
   int          ack_delay = 2;
   logic [23:0] ack_addrs[$];

   int         strobe_cnt = 0;
   logic [7:0] strobe_cmd = 8'h00;
   int         req_rise_cnt = 0;
   int         oe_cnt = 0;
   logic       req_prev = 1'b0;

   spi_flash_responder dut (
      .clk(clk), .resetn(resetn), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .cmd_strobe(cmd_strobe), .cmd(cmd),
      .underrun(underrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

   // Contents of the flash array as seen by the memory port.
   function automatic logic [7:0] mem_byte(input logic [23:0] a);
      return {a[6:0], a[7]} ^ a[15:8] ^ a[23:16] ^ 8'h5A;
   endfunction

   // Memory model: acknowledges a held request ack_delay cycles after it rises.
   initial begin
      int age;
      age = 0;
      mem_ack = 1'b0;
      mem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (mem_ack) begin
            mem_ack = 1'b0;
            age = 0;
         end else if (resetn && mem_req && ack_en) begin
            age++;
            if (age >= ack_delay) begin
               mem_ack = 1'b1;
               mem_rdata = mem_byte(mem_addr);
               ack_addrs.push_back(mem_addr);
               age = 0;
            end
         end else begin
            age = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cmd_strobe) begin
            strobe_cnt++;
            strobe_cmd = cmd;
         end
         if (mem_req && !req_prev) req_rise_cnt++;
         req_prev = mem_req;
         if (spi_miso_oe) oe_cnt++;
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nb; i++) begin
         spi_mosi = tx[7-i];
         wait_clk(HALF);
         rx = {rx[6:0], spi_miso};
         spi_sck = 1'b1;
         wait_clk(HALF);
         spi_sck = 1'b0;
      end
   endtask

   task automatic cs_low();
      spi_cs = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic cs_high();
      wait_clk(HALF);
      spi_cs = 1'b1;
      wait_clk(HALF);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      wait_clk(4);
      checks++; if (spi_miso !== 1'b0)    begin errors++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
      checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", spi_miso_oe); end
      checks++; if (mem_req !== 1'b0)     begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
      checks++; if (mem_addr !== 24'd0)   begin errors++; $display("FAIL reset_addr: got %h want 000000", mem_addr); end
      checks++; if (cmd !== 8'h00)        begin errors++; $display("FAIL reset_cmd: got %h want 00", cmd); end
      checks++; if (cmd_strobe !== 1'b0)  begin errors++; $display("FAIL reset_strobe: got %b want 0", cmd_strobe); end
      checks++; if (underrun !== 1'b0)    begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
      resetn = 1'b1;
      wait_clk(2 * HALF);
      $display("reset: outputs checked");
   endtask

   task automatic test_jedec();
      logic [7:0] rx, exp;
      int n, s0;
      n  = 5 + int'($urandom_range(0, 3));
      s0 = strobe_cnt;
      cs_low();
      spi_bits(8'h9F, 8, rx);
      for (int i = 0; i < n; i++) begin
         spi_bits(8'($urandom), 8, rx);
         exp = (i == 0) ? JEDEC[23:16] : (i == 1) ? JEDEC[15:8] : (i == 2) ? JEDEC[7:0] : 8'h00;
         checks++; if (rx !== exp) begin errors++; $display("FAIL jedec_byte%0d: got %h want %h", i, rx, exp); end
      end
      cs_high();
      checks++; if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL jedec_strobes: got %0d want 1", strobe_cnt - s0); end
      checks++; if (strobe_cmd !== 8'h9F) begin errors++; $display("FAIL jedec_cmd: got %h want 9f", strobe_cmd); end
      $display("jedec: %0d bytes", n);
   endtask

   task automatic test_status();
      logic [7:0] rx;
      int n;
      n = int'($urandom_range(1, 4));
      cs_low();
      spi_bits(8'h05, 8, rx);
      for (int i = 0; i < n; i++) begin
         spi_bits(8'($urandom), 8, rx);
         checks++; if (rx !== STAT) begin errors++; $display("FAIL status_byte%0d: got %h want %h", i, rx, STAT); end
      end
      checks++; if (spi_miso_oe !== 1'b1) begin errors++; $display("FAIL status_oe: got %b want 1", spi_miso_oe); end
      cs_high();
      checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL status_oe_off: got %b want 0", spi_miso_oe); end
      $display("status: %0d bytes", n);
   endtask

   task automatic test_read(input logic [23:0] a, input int n, input int dly);
      logic [7:0]  rx;
      logic [23:0] ea;
      ack_delay = dly;
      ack_addrs.delete();
      cs_low();
      spi_bits(8'h03, 8, rx);
      spi_bits(a[23:16], 8, rx);
      spi_bits(a[15:8], 8, rx);
      spi_bits(a[7:0], 8, rx);
      for (int i = 0; i < n; i++) begin
         spi_bits(8'($urandom), 8, rx);
         ea = a + 24'(i);
         checks++; if (rx !== mem_byte(ea)) begin errors++; $display("FAIL read_data@%h: got %h want %h", ea, rx, mem_byte(ea)); end
      end
      cs_high();
      wait_clk(10);
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL read_underrun: got %b want 0", underrun); end
      checks++; if (mem_req !== 1'b0)  begin errors++; $display("FAIL read_req_drain: got %b want 0", mem_req); end
      checks++; if (ack_addrs.size() < n) begin errors++; $display("FAIL read_req_count: got %0d want >=%0d", ack_addrs.size(), n); end
      for (int i = 0; i < n && i < ack_addrs.size(); i++) begin
         ea = a + 24'(i);
         checks++; if (ack_addrs[i] !== ea) begin errors++; $display("FAIL read_addr%0d: got %h want %h", i, ack_addrs[i], ea); end
      end
      $display("read: addr=%h bytes=%0d ack_delay=%0d", a, n, dly);
   endtask

   task automatic test_underrun();
      logic [7:0]  rx;
      logic [23:0] a;
      int          waited;
      a = 24'($urandom);
      ack_en = 1'b0;
      cs_low();
      spi_bits(8'h03, 8, rx);
      spi_bits(a[23:16], 8, rx);
      spi_bits(a[15:8], 8, rx);
      spi_bits(a[7:0], 8, rx);
      spi_bits(8'h00, 8, rx);
      checks++; if (rx !== 8'hFF)      begin errors++; $display("FAIL underrun_data: got %h want ff", rx); end
      checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_flag: got %b want 1", underrun); end
      cs_high();
      checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b want 1", underrun); end
      checks++; if (mem_req !== 1'b1)  begin errors++; $display("FAIL underrun_req_held: got %b want 1", mem_req); end
      checks++; if (mem_addr !== a)    begin errors++; $display("FAIL underrun_addr_held: got %h want %h", mem_addr, a); end
      ack_en = 1'b1;
      waited = 0;
      while (mem_req && waited < 20) begin
         wait_clk(1);
         waited++;
      end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL underrun_req_release: got %b want 0", mem_req); end
      cs_low();
      wait_clk(5);
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b want 0", underrun); end
      cs_high();
      $display("underrun: addr=%h", a);
   endtask

   task automatic test_abort();
      logic [7:0] rx;
      int s0, r0;
      s0 = strobe_cnt;
      r0 = req_rise_cnt;
      cs_low();
      spi_bits(8'h03, 8, rx);
      spi_bits(8'($urandom), 4, rx);
      spi_cs = 1'b1;
      wait_clk(3);
      checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL abort_addr_oe: got %b want 0", spi_miso_oe); end
      wait_clk(2 * HALF);
      checks++; if (req_rise_cnt != r0)   begin errors++; $display("FAIL abort_addr_req: got %0d rises want 0", req_rise_cnt - r0); end
      checks++; if (strobe_cnt - s0 != 1) begin errors++; $display("FAIL abort_addr_strobes: got %0d want 1", strobe_cnt - s0); end
      cs_low();
      spi_bits(8'h9F, 8, rx);
      spi_bits(8'h00, 8, rx);
      spi_bits(8'h00, 3, rx);
      checks++; if (spi_miso_oe !== 1'b1) begin errors++; $display("FAIL abort_data_oe_on: got %b want 1", spi_miso_oe); end
      spi_cs = 1'b1;
      wait_clk(3);
      checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL abort_data_oe_off: got %b want 0", spi_miso_oe); end
      wait_clk(HALF);
      s0 = strobe_cnt;
      cs_low();
      spi_bits(8'h9F, 5, rx);
      cs_high();
      checks++; if (strobe_cnt != s0) begin errors++; $display("FAIL abort_partial_strobe: got %0d want 0", strobe_cnt - s0); end
      $display("abort: mid-address, mid-data and partial command");
   endtask

   task automatic test_reset_mid_data();
      logic [7:0] rx;
      int s0, r0, o0;
      cs_low();
      spi_bits(8'h03, 8, rx);
      spi_bits(8'h00, 8, rx);
      spi_bits(8'h01, 8, rx);
      spi_bits(8'h00, 8, rx);
      spi_bits(8'h00, 8, rx);
      spi_bits(8'h00, 3, rx);
      resetn = 1'b0;
      wait_clk(2);
      checks++;
      if ({spi_miso, spi_miso_oe, mem_req, mem_addr, cmd, cmd_strobe, underrun} !== 37'd0) begin
         errors++;
         $display("FAIL midreset_outputs: got miso=%b oe=%b req=%b addr=%h cmd=%h strobe=%b underrun=%b want all 0",
                  spi_miso, spi_miso_oe, mem_req, mem_addr, cmd, cmd_strobe, underrun);
      end
      resetn = 1'b1;
      wait_clk(5);
      s0 = strobe_cnt;
      r0 = req_rise_cnt;
      o0 = oe_cnt;
      spi_bits(8'h9F, 8, rx);
      spi_bits(8'h00, 8, rx);
      cs_high();
      checks++; if (strobe_cnt != s0)   begin errors++; $display("FAIL midreset_ignore_strobe: got %0d want 0", strobe_cnt - s0); end
      checks++; if (req_rise_cnt != r0) begin errors++; $display("FAIL midreset_ignore_req: got %0d want 0", req_rise_cnt - r0); end
      checks++; if (oe_cnt != o0)       begin errors++; $display("FAIL midreset_ignore_oe: got %0d cycles want 0", oe_cnt - o0); end
      $display("reset mid-data: outputs cleared, stale transaction ignored");
   endtask

   task automatic test_back_to_back();
      logic [7:0] rx;
      cs_low();
      spi_bits(8'h9F, 8, rx);
      spi_bits(8'h00, 8, rx);
      checks++; if (rx !== JEDEC[23:16]) begin errors++; $display("FAIL b2b_jedec: got %h want %h", rx, JEDEC[23:16]); end
      cs_high();
      cs_low();
      spi_bits(8'h05, 8, rx);
      spi_bits(8'h00, 8, rx);
      checks++; if (rx !== STAT) begin errors++; $display("FAIL b2b_status: got %h want %h", rx, STAT); end
      cs_high();
      $display("back-to-back: jedec then status");
   endtask

   task automatic test_fastread();
      logic [7:0] rx;
      int o0;
      o0 = oe_cnt;
      ack_delay = 2;
      cs_low();
      spi_bits(8'h0B, 8, rx);
      spi_bits(8'h00, 8, rx);
      spi_bits(8'h00, 8, rx);
      spi_bits(8'h20, 8, rx);
      spi_bits(8'h00, 4, rx);
      checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL fast_dummy_oe: got %b want 0", spi_miso_oe); end
      spi_bits(8'h00, 4, rx);
`ifdef SPI_FLASH_RESP_FASTREAD_EN
      for (int i = 0; i < 2; i++) begin
         spi_bits(8'h00, 8, rx);
         checks++; if (rx !== mem_byte(24'h20 + 24'(i))) begin errors++; $display("FAIL fast_data%0d: got %h want %h", i, rx, mem_byte(24'h20 + 24'(i))); end
      end
      cs_high();
      wait_clk(10);
`else
      spi_bits(8'h00, 8, rx);
      spi_bits(8'h00, 8, rx);
      cs_high();
      checks++; if (oe_cnt != o0) begin errors++; $display("FAIL fast_disabled_oe: got %0d cycles want 0", oe_cnt - o0); end
`endif
      checks++; if (strobe_cmd !== 8'h0B) begin errors++; $display("FAIL fast_cmd: got %h want 0b", strobe_cmd); end
      $display("fast read: addr=000020");
   endtask

   initial begin
      resetn   = 1'b0;
      spi_cs   = 1'b1;
      spi_sck  = 1'b0;
      spi_mosi = 1'b0;
      test_reset();
      test_jedec();
      test_status();
      test_read(24'h001000, 4, 2);
      for (int k = 0; k < 3; k++)
         test_read(24'($urandom), int'($urandom_range(1, 5)), int'($urandom_range(1, 3)));
      test_read(24'hFFFFFF, 2, 2);
      test_underrun();
      test_abort();
      test_reset_mid_data();
      test_back_to_back();
      test_fastread();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
